// File: rtl/filter_unit_mc.sv
// Generic FIFO: WIDTH-bit entries, DEPTH deep (power of 2), registered head.
// Latency: one cycle from push to rd_vld; no combinational write-to-read bypass.
// Backpressure: wr_rdy drops when full unless a pop happens the same cycle.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             push;
  logic             pop;

  assign rd_vld = (cnt != '0);
  assign pop    = rd_vld & rd_rdy;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_rdy = (cnt != (AW+1)'(DEPTH)) | pop;
  assign push   = wr_vld & wr_rdy;
  assign rd_dat = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// Multi-channel serial sample filter: limit loads, optional moving average, clamp, output FIFO.
// Latency: word's final bit in cycle T -> dispatch T+1 -> FIFO push T+2 -> extvalid_out in T+3.
// Backpressure: valid/ready on ext side; results arriving at a full FIFO are dropped and flag ovf_out.
module filter_unit_mc #(
  parameter int DATABITS  = 16,
  parameter int NCH       = 4,
  parameter int LOG2TAPS  = 2,
  parameter int FIFODEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sde_in,
  input  logic                    sd_in,
  input  logic [$clog2(NCH)-1:0]  ch_in,
  input  logic                    ul_in,
  input  logic                    dl_in,
  input  logic                    mode_in,
  output logic [DATABITS-1:0]     ext_out,
  output logic [$clog2(NCH)-1:0]  extch_out,
  output logic                    extvalid_out,
  input  logic                    extready_in,
  output logic                    ovf_out
);
  localparam int CHW  = $clog2(NCH);
  localparam int BCW  = $clog2(DATABITS);
  localparam int NTAP = 1 << LOG2TAPS;
  localparam int NH   = NTAP - 1;             // history entries summed with the new sample
  localparam int HD   = (NH < 1) ? 1 : NH;    // keep the array non-empty for single-tap builds
  localparam int SW   = DATABITS + LOG2TAPS;

  // Receiver state
  logic [BCW-1:0]      bcnt;
  logic [DATABITS-2:0] sh;
  logic [DATABITS-1:0] sh_next;
  logic                last_bit;

  // Captured word and its tags
  logic [DATABITS-1:0] word_q;
  logic [CHW-1:0]      ch_q;
  logic                ul_q;
  logic                dl_q;
  logic                mode_q;
  logic                wvld_q;

  // Per-channel state
  logic [DATABITS-1:0] ul_lim [NCH];
  logic [DATABITS-1:0] dl_lim [NCH];
  logic [DATABITS-1:0] hist   [NCH][HD];

  // Sample datapath
  logic [SW-1:0]       sum;
  logic [DATABITS-1:0] avg;
  logic [DATABITS-1:0] pre;
  logic [DATABITS-1:0] clamped;

  // Registered result waiting to enter the FIFO
  logic [DATABITS-1:0] res_q;
  logic [CHW-1:0]      res_ch_q;
  logic                res_vld_q;

  logic                fifo_wr_rdy;
  logic [CHW+DATABITS-1:0] fifo_rd_dat;
  logic                ovf_q;

  assign sh_next  = {sh, sd_in};
  assign last_bit = sde_in && (bcnt == BCW'(DATABITS - 1));

  // Shift serial bits in; on the final bit latch the whole word plus its tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt   <= '0;
      sh     <= '0;
      word_q <= '0;
      ch_q   <= '0;
      ul_q   <= 1'b0;
      dl_q   <= 1'b0;
      mode_q <= 1'b0;
      wvld_q <= 1'b0;
    end else begin
      wvld_q <= 1'b0;
      if (sde_in) begin
        sh <= sh_next[DATABITS-2:0];
        if (last_bit) begin
          bcnt   <= '0;
          word_q <= sh_next;
          ch_q   <= ch_in;
          ul_q   <= ul_in;
          dl_q   <= dl_in;
          mode_q <= mode_in;
          wvld_q <= 1'b1;
        end else begin
          bcnt <= bcnt + BCW'(1);
        end
      end else begin
        // Enable dropped mid-word: the partial word is abandoned.
        bcnt <= '0;
      end
    end
  end

  // Average over the new sample and the channel's history, then clamp to its limits.
  always_comb begin
    sum = SW'(word_q);
    for (int i = 0; i < NH; i++) sum = sum + SW'(hist[ch_q][i]);
    avg     = DATABITS'(sum >> LOG2TAPS);
    pre     = mode_q ? avg : word_q;
    clamped = pre;
    // An inverted limit pair (DL above UL) resolves to UL.
    if ((pre > ul_lim[ch_q]) || (dl_lim[ch_q] > ul_lim[ch_q])) clamped = ul_lim[ch_q];
    else if (pre < dl_lim[ch_q])                               clamped = dl_lim[ch_q];
  end

  // Dispatch a captured word: limit load, or history shift plus registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q     <= '0;
      res_ch_q  <= '0;
      res_vld_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        ul_lim[c] <= '1;
        dl_lim[c] <= '0;
        for (int i = 0; i < HD; i++) hist[c][i] <= '0;
      end
    end else begin
      res_vld_q <= 1'b0;
      if (wvld_q) begin
        if (ul_q) begin
          ul_lim[ch_q] <= word_q;
        end else if (dl_q) begin
          dl_lim[ch_q] <= word_q;
        end else begin
          // History advances in bypass mode too, so switching to averaging sees real data.
          hist[ch_q][0] <= word_q;
          for (int i = 1; i < HD; i++) hist[ch_q][i] <= hist[ch_q][i-1];
          res_q     <= clamped;
          res_ch_q  <= ch_q;
          res_vld_q <= 1'b1;
        end
      end
    end
  end

  fifo #(
    .WIDTH (CHW + DATABITS),
    .DEPTH (FIFODEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (res_vld_q),
    .wr_rdy (fifo_wr_rdy),
    .wr_dat ({res_ch_q, res_q}),
    .rd_vld (extvalid_out),
    .rd_rdy (extready_in),
    .rd_dat (fifo_rd_dat)
  );

  // Sticky overflow: set when a result finds the FIFO full with no pop to make room.
  always_ff @(posedge clk) begin
    if (!rst_n)                          ovf_q <= 1'b0;
    else if (res_vld_q && !fifo_wr_rdy)  ovf_q <= 1'b1;
  end

  assign ext_out   = fifo_rd_dat[DATABITS-1:0];
  assign extch_out = fifo_rd_dat[DATABITS +: CHW];
  assign ovf_out   = ovf_q;
endmodule
